// File: rtl/muu_resp_arbiter_pkg.sv
// Shared definitions for the MUU response path: arbiter state encodings,
// the watchdog terminator word and a constant width helper.
package muu_pkg;

    localparam logic [1:0] ST_ARB   = 2'd0;
    localparam logic [1:0] ST_PASS  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam int MUU_WORD_W = 512;
    localparam logic [MUU_WORD_W-1:0] MUU_ABORT_WORD = 512'h00000000FEEBDAED;

    // Never returns less than 1 so a 2-port arbiter still gets a 1-bit index.
    function automatic int muu_clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/muu_resp_arbiter_if.sv
// Bundle of per-port response streams and the merged output stream.
// The arbiter takes the slave side; the upstream pipelines and TX take master.
interface muu_resp_arbiter_if
    import muu_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int META_WIDTH = 96
);
    localparam int DW = META_WIDTH + MUU_WORD_W;

    logic [NUM_PORTS*DW-1:0] in_data;
    logic [NUM_PORTS*8-1:0]  in_user;
    logic [NUM_PORTS-1:0]    in_valid;
    logic [NUM_PORTS-1:0]    in_last;
    logic [NUM_PORTS-1:0]    in_ready;

    logic [DW-1:0]           output_data;
    logic [7:0]              output_user;
    logic                    output_valid;
    logic                    output_last;
    logic                    output_ready;

    modport master (
        output in_data, in_user, in_valid, in_last, output_ready,
        input  in_ready, output_data, output_user, output_valid, output_last
    );

    modport slave (
        input  in_data, in_user, in_valid, in_last, output_ready,
        output in_ready, output_data, output_user, output_valid, output_last
    );

endinterface

// File: rtl/muu_resp_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after
// start_i, wrapping modulo N (N need not be a power of two).
module muu_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic          hit_o,
    output logic [IW-1:0] idx_o
);

    logic [IW:0] pos;

    // Scan from the far end so the candidate nearest to start_i overwrites last.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        pos   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = {1'b0, start_i} + (IW+1)'(k);
            if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
            if (req_i[pos[IW-1:0]]) begin
                hit_o = 1'b1;
                idx_o = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/muu_resp_arbiter.sv
// Packet-granular round-robin merge of per-partition response streams.
// Optional stall watchdog enabled by defining MUU_RESP_ARB_WATCHDOG_EN.
module muu_resp_arbiter
    import muu_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int META_WIDTH      = 96,
    parameter int WATCHDOG_CYCLES = 1024,
    parameter int GW              = muu_clog2(NUM_PORTS)
) (
    input  logic                clk,
    input  logic                rst_n,
    muu_resp_arbiter_if.slave   bus,
    output logic [GW-1:0]       grant_port,
    output logic [15:0]         wd_abort_count
);

    localparam int DW = META_WIDTH + MUU_WORD_W;
    localparam logic [GW-1:0] LAST_PORT = GW'(NUM_PORTS - 1);

    logic [1:0]           state_q, state_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [GW-1:0]        last_q, last_d;
    logic [DW-1:0]        odata_q, odata_d;
    logic [7:0]           ouser_q, ouser_d;
    logic                 ovalid_q, ovalid_d;
    logic                 olast_q, olast_d;

    logic [GW-1:0]        start_idx;
    logic                 hit;
    logic [GW-1:0]        pick;
    logic [NUM_PORTS-1:0] rdy;
    logic                 can_load;
    logic                 accept;
    logic                 g_valid;
    logic                 g_last;
    logic [DW-1:0]        g_data;
    logic [7:0]           g_user;

    assign start_idx = (last_q == LAST_PORT) ? '0 : last_q + 1'b1;

    muu_rr_pick #(
        .N  (NUM_PORTS),
        .IW (GW)
    ) u_pick (
        .req_i   (bus.in_valid),
        .start_i (start_idx),
        .hit_o   (hit),
        .idx_o   (pick)
    );

    assign g_valid  = bus.in_valid[grant_q];
    assign g_last   = bus.in_last[grant_q];
    assign g_data   = bus.in_data[int'(grant_q)*DW +: DW];
    assign g_user   = bus.in_user[int'(grant_q)*8 +: 8];
    assign can_load = !ovalid_q || bus.output_ready;

    // Ready depends only on state and output_ready, never on in_valid.
    always_comb begin
        rdy = '0;
        if (state_q == ST_PASS) rdy[grant_q] = can_load;
`ifdef MUU_RESP_ARB_WATCHDOG_EN
        if (state_q == ST_FLUSH) rdy[grant_q] = 1'b1;
`endif
    end

    assign accept = |(rdy & bus.in_valid);

`ifdef MUU_RESP_ARB_WATCHDOG_EN
    localparam int CW = muu_clog2(WATCHDOG_CYCLES + 1);
    localparam logic [CW-1:0] STALL_LIMIT = CW'(WATCHDOG_CYCLES);

    logic [CW-1:0] stall_q, stall_d;
    logic [7:0]    seen_q, seen_d;
    logic [15:0]   abort_q, abort_d;
    logic          wd_fire;

    // Terminator waits for a free output slot; a returning beat takes priority.
    assign wd_fire = (state_q == ST_PASS) && (stall_q == STALL_LIMIT) && !g_valid && can_load;

    always_comb begin
        stall_d = stall_q;
        seen_d  = seen_q;
        abort_d = abort_q;
        if (state_q != ST_PASS || accept) begin
            stall_d = '0;
        end else if (!g_valid && stall_q != STALL_LIMIT) begin
            stall_d = stall_q + 1'b1;
        end
        if (state_q == ST_ARB && hit) begin
            seen_d = bus.in_user[int'(pick)*8 +: 8];
        end else if (accept) begin
            seen_d = g_user;
        end
        if (wd_fire && abort_q != 16'hFFFF) abort_d = abort_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            seen_q  <= '0;
            abort_q <= '0;
        end else begin
            stall_q <= stall_d;
            seen_q  <= seen_d;
            abort_q <= abort_d;
        end
    end

    assign wd_abort_count = abort_q;
`else
    assign wd_abort_count = '0;
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        odata_d  = odata_q;
        ouser_d  = ouser_q;
        olast_d  = olast_q;
        ovalid_d = ovalid_q && !bus.output_ready;
        case (state_q)
            ST_ARB: begin
                if (hit) begin
                    grant_d = pick;
                    state_d = ST_PASS;
                end
            end
            ST_PASS: begin
                if (accept) begin
                    odata_d  = g_data;
                    ouser_d  = g_user;
                    olast_d  = g_last;
                    ovalid_d = 1'b1;
                    if (g_last) begin
                        last_d  = grant_q;
                        state_d = ST_ARB;
                    end
                end
`ifdef MUU_RESP_ARB_WATCHDOG_EN
                else if (wd_fire) begin
                    odata_d  = {{META_WIDTH{1'b0}}, MUU_ABORT_WORD};
                    ouser_d  = seen_q;
                    olast_d  = 1'b1;
                    ovalid_d = 1'b1;
                    state_d  = ST_FLUSH;
                end
`endif
            end
`ifdef MUU_RESP_ARB_WATCHDOG_EN
            ST_FLUSH: begin
                if (accept && g_last) begin
                    last_d  = grant_q;
                    state_d = ST_ARB;
                end
            end
`endif
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ARB;
            grant_q  <= '0;
            last_q   <= LAST_PORT;
            odata_q  <= '0;
            ouser_q  <= '0;
            ovalid_q <= 1'b0;
            olast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            odata_q  <= odata_d;
            ouser_q  <= ouser_d;
            ovalid_q <= ovalid_d;
            olast_q  <= olast_d;
        end
    end

    assign bus.in_ready     = rdy;
    assign bus.output_data  = odata_q;
    assign bus.output_user  = ouser_q;
    assign bus.output_valid = ovalid_q;
    assign bus.output_last  = olast_q;
    assign grant_port       = grant_q;

endmodule

// File: tb/tb_muu_resp_arbiter.sv
// Directed scoreboard bench for muu_resp_arbiter; the watchdog scenario is
// selected by MUU_RESP_ARB_WATCHDOG_EN, matching the RTL build.
module tb_muu_resp_arbiter;
    import muu_pkg::*;

    localparam int NP = 4;
    localparam int MW = 96;
    localparam int DW = MW + 512;
    localparam int WD = 16;

    typedef struct {
        logic [DW-1:0] data;
        logic [7:0]    user;
        logic          last;
        logic          idle;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [7:0]    user;
        logic          last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  grant_port;
    logic [15:0] wd_abort_count;

    beat_t pq [NP][$];
    exp_t  exp_q[$];
    int    ocyc[$];
    bit    shown [NP];
    int    cyc = 0;
    int    checks = 0;
    int    passed = 0;
    int    fails = 0;
    int    t0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muu_resp_arbiter_if #(.NUM_PORTS(NP), .META_WIDTH(MW)) bus ();

    muu_resp_arbiter #(
        .NUM_PORTS       (NP),
        .META_WIDTH      (MW),
        .WATCHDOG_CYCLES (WD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .grant_port     (grant_port),
        .wd_abort_count (wd_abort_count)
    );

    function automatic logic [DW-1:0] mk(input int p, input int s);
        logic [DW-1:0] d;
        d = '0;
        d[DW-1 -: 8] = 8'(p + 1);
        d[31:0]      = 32'h0001_0000 + 32'(p * 256 + s);
        return d;
    endfunction

    function automatic logic [7:0] uid(input int p, input int s);
        return 8'((p << 4) | (s & 15));
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sendb(input int p, input int s, input logic l);
        beat_t b;
        b.data = mk(p, s);
        b.user = uid(p, s);
        b.last = l;
        b.idle = 1'b0;
        pq[p].push_back(b);
    endtask

    task automatic idle(input int p, input int n);
        beat_t b;
        b.data = '0;
        b.user = '0;
        b.last = 1'b0;
        b.idle = 1'b1;
        for (int i = 0; i < n; i++) pq[p].push_back(b);
    endtask

    task automatic expb(input int p, input int s, input logic l);
        exp_t e;
        e.data = mk(p, s);
        e.user = uid(p, s);
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        chk(tag, DW'(exp_q.size()), '0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        ocyc.delete();
        for (int p = 0; p < NP; p++) pq[p].delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Upstream driver: presents each port's queue head, pops on handshake.
    initial begin
        logic [NP-1:0] accs;
        bus.in_valid = '0;
        bus.in_last  = '0;
        bus.in_data  = '0;
        bus.in_user  = '0;
        forever begin
            @(negedge clk);
            accs = bus.in_valid & bus.in_ready;
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (pq[p].size() > 0 && shown[p] && (pq[p][0].idle || accs[p]))
                    void'(pq[p].pop_front());
                if (pq[p].size() > 0) begin
                    shown[p]                 = 1'b1;
                    bus.in_valid[p]          = !pq[p][0].idle;
                    bus.in_last[p]           = pq[p][0].last;
                    bus.in_data[p*DW +: DW]  = pq[p][0].data;
                    bus.in_user[p*8 +: 8]    = pq[p][0].user;
                end else begin
                    shown[p]        = 1'b0;
                    bus.in_valid[p] = 1'b0;
                    bus.in_last[p]  = 1'b0;
                end
            end
        end
    end

    // Output monitor: scoreboard compare on every transfer, stall rule on holds.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.output_valid && bus.output_ready) begin
                chk("have_expected", DW'(exp_q.size() > 0), DW'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("out_data", bus.output_data, e.data);
                    chk("out_user", DW'(bus.output_user), DW'(e.user));
                    chk("out_last", DW'(bus.output_last), DW'(e.last));
                end
                ocyc.push_back(cyc);
            end
            if (rst_n && bus.output_valid && !bus.output_ready)
                chk("stall_in_ready", DW'(bus.in_ready), '0);
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n = 1'b0;
        bus.output_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", DW'(bus.output_valid), '0);
        chk("rst_last", DW'(bus.output_last), '0);
        chk("rst_data", bus.output_data, '0);
        chk("rst_user", DW'(bus.output_user), '0);
        chk("rst_in_ready", DW'(bus.in_ready), '0);
        chk("rst_grant", DW'(grant_port), '0);
        chk("rst_wd_count", DW'(wd_abort_count), '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two simultaneous 3-beat packets on ports 0 and 2.
        t0 = cyc;
        ocyc.delete();
        for (int s = 0; s < 3; s++) begin
            sendb(0, s, s == 2);
            sendb(2, s, s == 2);
        end
        for (int s = 0; s < 3; s++) expb(0, s, s == 2);
        for (int s = 0; s < 3; s++) expb(2, s, s == 2);
        drain("t1_drain", 60);
        chk("t1_beats", DW'(ocyc.size()), DW'(6));
        if (ocyc.size() == 6) begin
            chk("t1_first_latency", DW'(ocyc[0] - t0), DW'(3));
            chk("t1_gap01", DW'(ocyc[1] - ocyc[0]), DW'(1));
            chk("t1_gap12", DW'(ocyc[2] - ocyc[1]), DW'(1));
            chk("t1_idle_gap", DW'(ocyc[3] - ocyc[2]), DW'(2));
            chk("t1_gap34", DW'(ocyc[4] - ocyc[3]), DW'(1));
            chk("t1_gap45", DW'(ocyc[5] - ocyc[4]), DW'(1));
        end

        // All ports stream single-beat packets: strict rotation 0,1,2,3.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NP; p++) begin
                sendb(p, r, 1'b1);
                expb(p, r, 1'b1);
            end
        drain("t2_drain", 80);

        // 5-beat packet from port 1 with output_ready toggling every cycle.
        for (int s = 0; s < 5; s++) begin
            sendb(1, s, s == 4);
            expb(1, s, s == 4);
        end
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1 bus.output_ready = ~bus.output_ready;
        end
        bus.output_ready = 1'b1;
        chk("t3_drain", DW'(exp_q.size()), '0);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a port-3 packet.
        for (int s = 0; s < 4; s++) begin
            sendb(3, s, s == 3);
            expb(3, s, s == 3);
        end
        repeat (4) @(negedge clk);
        chk("t4_busy_before_reset", DW'(bus.output_valid), DW'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("t4_async_valid", DW'(bus.output_valid), '0);
        chk("t4_async_data", bus.output_data, '0);
        chk("t4_async_user", DW'(bus.output_user), '0);
        chk("t4_async_last", DW'(bus.output_last), '0);
        chk("t4_async_in_ready", DW'(bus.in_ready), '0);
        chk("t4_async_grant", DW'(grant_port), '0);
        exp_q.delete();
        for (int p = 0; p < NP; p++) pq[p].delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        sendb(3, 10, 1'b1);
        sendb(1, 10, 1'b1);
        expb(1, 10, 1'b1);
        expb(3, 10, 1'b1);
        drain("t4_post_reset_drain", 40);

        // Port 1 stalls 20 cycles mid-packet; port 2 waits behind it.
        sendb(1, 0, 1'b0);
        sendb(1, 1, 1'b0);
        idle(1, 20);
        sendb(1, 2, 1'b0);
        sendb(1, 3, 1'b1);
        sendb(2, 7, 1'b1);
        expb(1, 0, 1'b0);
        expb(1, 1, 1'b0);
`ifdef MUU_RESP_ARB_WATCHDOG_EN
        begin
            exp_t term;
            term.data = {{MW{1'b0}}, MUU_ABORT_WORD};
            term.user = uid(1, 1);
            term.last = 1'b1;
            exp_q.push_back(term);
        end
        expb(2, 7, 1'b1);
        drain("t5_drain", 150);
        chk("t5_wd_count", DW'(wd_abort_count), DW'(1));
`else
        expb(1, 2, 1'b0);
        expb(1, 3, 1'b1);
        expb(2, 7, 1'b1);
        drain("t6_drain", 150);
        chk("t6_wd_count", DW'(wd_abort_count), '0);
`endif
        repeat (4) @(negedge clk);
        chk("final_queue_empty", DW'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/muu_resp_arbiter.md
# muu_resp_arbiter

Packet-granular round-robin arbiter that merges the response streams of several value-get pipelines, one per memory partition, onto the single response path toward the network TX. A grant is held from the first beat of a packet until its `last` beat is accepted, so packets never interleave. An optional watchdog closes a packet whose source stalls mid-packet.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of input response streams (2..8).
- `META_WIDTH`, 96: metadata width carried alongside each 512-bit word.
- `WATCHDOG_CYCLES`, 1024: stall limit in cycles. Used only with the watchdog.

Ports (flattened vectors; port i occupies slice i):
- `clk`  in  1: single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_data`  in  NUM_PORTS*(META_WIDTH+512): per-port {meta, word}.
- `in_user`  in  NUM_PORTS*8: per-port user id.
- `in_valid`  in  NUM_PORTS: per-port beat valid.
- `in_last`  in  NUM_PORTS: per-port last beat of packet.
- `in_ready`  out  NUM_PORTS: per-port accept.
- `output_data`  out  META_WIDTH+512: registered merged beat.
- `output_user`  out  8: user id of the current beat.
- `output_valid`  out  1: beat valid.
- `output_last`  out  1: last beat of packet.
- `output_ready`  in  1: downstream accept.
- `grant_port`  out  clog2(NUM_PORTS): index of the owning port, for debug.
- `wd_abort_count`  out  16: number of watchdog aborts (saturating).

## Operation
States: `ST_ARB`, `ST_PASS`, `ST_FLUSH`.
- **ST_ARB**
  - Search `in_valid` round-robin, starting at `(last_grant+1) mod NUM_PORTS`.
  - On a hit, latch `grant_port` and go to `ST_PASS`. No beat is accepted in this cycle.
  - With no request, stay in `ST_ARB`.
- **ST_PASS**
  - `in_ready[g] = (!output_valid | output_ready)`; all other ready bits are 0.
  - An accepted beat is copied into the output register: data, user, last, `output_valid=1`.
  - Accepting the beat with `in_last=1` sets `last_grant=g` and moves to `ST_ARB`.
- **ST_FLUSH** (watchdog only)
  - `in_ready[g]=1` unconditionally; beats are discarded.
  - Accepting the beat with `in_last=1` moves to `ST_ARB`.
- **Output register**
  - Cleared (`output_valid=0`) on `output_valid & output_ready` unless reloaded in the same cycle.
  - Holds its contents while `output_ready=0`.
- **Width rules**
  - `grant_port` arithmetic wraps modulo `NUM_PORTS`; this also applies to non-power-of-2 counts.
  - `wd_abort_count` saturates at 16'hFFFF.
- **Boundary conditions**
  - A single requester is granted every packet, with one `ST_ARB` cycle between its packets.
  - A port that drops `in_valid` during `ST_ARB` before the grant is latched is not granted. Arbitration samples the current cycle only.
  - A single-beat packet (`in_last=1` on the first beat) is legal.

## Timing
- Reset values: `output_valid=0`, `output_last=0`, `output_data=0`, `output_user=0`, `in_ready=0`, `grant_port=0`, `last_grant=NUM_PORTS-1` (so port 0 wins first), `wd_abort_count=0`, state `ST_ARB`, stall counter 0.
- Latency: the first beat of a packet appears on the output 2 cycles after `in_valid` rises (1 cycle arbitration, 1 cycle register). Later beats have 1-cycle latency at full throughput.
- Packet-to-packet overhead is exactly 1 idle cycle (`ST_ARB`).
- `in_ready` is combinational from state and `output_ready`. No combinational path exists from `in_valid` to `in_ready`.
- Reset asserted mid-packet abandons the packet immediately. After reset the upstream must restart at a packet boundary.

## Configuration
Macro: `MUU_RESP_ARB_WATCHDOG_EN`.
- **Defined**
  - In `ST_PASS`, a counter counts cycles with `in_valid[g]=0`. It resets on every accepted beat.
  - When the counter reaches `WATCHDOG_CYCLES`:
    - Load the output with `output_data` = {`META_WIDTH'0`, 512'h00000000FEEBDAED}, `output_last=1`, and `output_user` equal to the last user seen on that port.
    - Increment `wd_abort_count`.
    - Enter `ST_FLUSH`.
  - Terminator insertion waits until the output register is free.
- **Not defined**
  - No counter exists and `ST_FLUSH` is unreachable.
  - `wd_abort_count` is tied to 0.
  - The grant is held indefinitely.

## Structure
- The shared package `muu_pkg` holds the state encodings, the terminator constant `MUU_ABORT_WORD = 512'h00000000FEEBDAED`, and a `clog2`-style width function.
- One sub-module, `muu_rr_pick`: a combinational round-robin priority encoder with inputs (request vector, start index) and outputs (hit, index). It is reusable by other arbiters in the design.

## Test plan
1. Ports 0 and 2 each present a 3-beat packet simultaneously, `output_ready=1`.
   - Required: port 0's 3 beats, 1 idle cycle, then port 2's 3 beats.
   - `output_last` asserts only on beats 3 and 6; no interleaving.
2. All 4 ports continuously request single-beat packets.
   - Required: grant order 0,1,2,3,0,…
   - Each output beat carries its source port's `in_user`.
3. `output_ready` toggles 1/0 every cycle during a 5-beat packet from port 1.
   - Required: all 5 beats delivered in order, none duplicated or lost.
   - `in_ready[1]` is low whenever the output is full and stalled.
4. `rst_n` is pulsed low mid-packet on port 3.
   - Required: outputs return to their reset values asynchronously.
   - The next grant after reset goes to the lowest requesting port starting at 0.
5. With the watchdog enabled and `WATCHDOG_CYCLES=16`: port 1 sends 2 beats, then holds `in_valid=0` for 20 cycles, then sends 2 more beats, the second with `in_last=1`.
   - Required: terminator `...FEEBDAED` with `last=1` is emitted after 16 stall cycles.
   - `wd_abort_count=1`; the 2 late beats are discarded; arbitration then resumes.
6. With the watchdog disabled, same stimulus as scenario 5.
   - Required: no terminator; all 4 beats delivered in order with `last` on the 4th.
